// File: rtl/lock_pkg.sv
// Shared types, LED patterns and width helpers for the combination lock.
package lock_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_ERROR    = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_t;

  // Active-low LED patterns, ordered {red, green, blue}
  localparam logic [2:0] LED_LOCKED   = 3'b011;
  localparam logic [2:0] LED_ENTRY    = 3'b110;
  localparam logic [2:0] LED_UNLOCKED = 3'b101;
  localparam logic [2:0] LED_LOCKOUT  = 3'b010;
  localparam logic [2:0] LED_OFF      = 3'b111;

  // Bits needed for a counter that must hold values 0..max_val (at least 1)
  function automatic int cnt_w(input int max_val);
    if (max_val <= 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

  // LED pattern shown while in a given state
  function automatic logic [2:0] led_of(input state_t st);
    logic [2:0] led;
    case (st)
      ST_LOCKED:   led = LED_LOCKED;
      ST_ENTRY:    led = LED_ENTRY;
      ST_ERROR:    led = LED_ENTRY;
      ST_UNLOCKED: led = LED_UNLOCKED;
      ST_LOCKOUT:  led = LED_LOCKOUT;
      ST_CHECK:    led = LED_OFF;
      default:     led = LED_LOCKED;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Raw active-low button: 2-flop synchroniser plus a tick-rate press detector.
// A press is a released-to-pressed change between two consecutive tick samples.
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_btn_n,
  output logic o_press
);

  logic r_meta;
  logic r_sync;
  logic r_samp;

  // Synchronise the raw level and keep the previous tick sample; reset to released
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_samp <= 1'b1;
    end else begin
      r_meta <= i_btn_n;
      r_sync <= r_meta;
      if (i_tick) begin
        r_samp <= r_sync;
      end
    end
  end

  assign o_press = i_tick & r_samp & ~r_sync;

endmodule

// File: rtl/lock_fsm_multi.sv
// Multi-digit combination lock: tick divider, lock FSM, code register,
// tries/lockout/relock counters and buzzer timer. Outputs are registered.
module lock_fsm_multi
  import lock_pkg::*;
#(
  parameter int                         DIGITS        = 4,
  parameter int                         DIGIT_W       = 2,
  parameter logic [DIGITS*DIGIT_W-1:0]  PASSWORD      = 8'h9C,
  parameter int                         TICK_DIV      = 2_000_000,
  parameter int                         MAX_TRIES     = 3,
  parameter int                         LOCKOUT_TICKS = 200,
  parameter int                         RELOCK_TICKS  = 300,
  parameter int                         BEEP_SHORT    = 10,
  parameter int                         BEEP_LONG     = 25
) (
  input  logic                                        hw_clk,
  input  logic                                        btn_reset,
  input  logic                                        btn_toggle,
  input  logic                                        btn_next,
  input  logic                                        btn_enter,
  output logic                                        led_red,
  output logic                                        led_green,
  output logic                                        led_blue,
  output logic                                        buzzer,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx,
  output logic [$clog2(MAX_TRIES + 1)-1:0]            tries_left,
  output logic                                        locked_out
);

  localparam int CODE_W      = DIGITS * DIGIT_W;
  localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TRY_W       = $clog2(MAX_TRIES + 1);
  localparam int DIV_W       = cnt_w(TICK_DIV - 1);
  localparam int LOCK_W      = cnt_w(LOCKOUT_TICKS);
  localparam int IDLE_W      = cnt_w(RELOCK_TICKS);
  localparam int BEEP_MAX    = (BEEP_LONG > BEEP_SHORT) ? BEEP_LONG : BEEP_SHORT;
  localparam int BEEP_W      = cnt_w(BEEP_MAX);
  localparam int RELOCK_LAST = (RELOCK_TICKS > 0) ? RELOCK_TICKS - 1 : 0;

  // Tick divider
  logic [DIV_W-1:0]  r_div;
  logic              w_tick;

  // Synchronised presses
  logic              w_press_toggle;
  logic              w_press_next;
  logic              w_press_enter;
  logic              w_press_any;

  // FSM and datapath registers with their next values
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [TRY_W-1:0]  r_tries;
  logic [TRY_W-1:0]  w_tries_nxt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [LOCK_W-1:0] w_lock_nxt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_nxt;
  logic [BEEP_W-1:0] r_beep_cnt;
  logic [BEEP_W-1:0] w_beep_nxt;

  // Output registers
  logic [2:0]        r_led;
  logic              r_buzzer;
  logic              r_locked_out;

  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

  // Free-running divider producing a one-cycle tick every TICK_DIV cycles
  always_ff @(posedge hw_clk) begin
    if (btn_reset) begin
      r_div <= DIV_W'(0);
    end else if (w_tick) begin
      r_div <= DIV_W'(0);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  btn_sync_edge u_sync_toggle (
    .i_clk   (hw_clk),
    .i_rst   (btn_reset),
    .i_tick  (w_tick),
    .i_btn_n (btn_toggle),
    .o_press (w_press_toggle)
  );

  btn_sync_edge u_sync_next (
    .i_clk   (hw_clk),
    .i_rst   (btn_reset),
    .i_tick  (w_tick),
    .i_btn_n (btn_next),
    .o_press (w_press_next)
  );

  btn_sync_edge u_sync_enter (
    .i_clk   (hw_clk),
    .i_rst   (btn_reset),
    .i_tick  (w_tick),
    .i_btn_n (btn_enter),
    .o_press (w_press_enter)
  );

  assign w_press_any = w_press_toggle | w_press_next | w_press_enter;

  // Next-state and next datapath values; everything holds outside tick cycles
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_idx_nxt   = r_idx;
    w_tries_nxt = r_tries;
    w_lock_nxt  = r_lock_cnt;
    w_idle_nxt  = r_idle_cnt;
    w_beep_nxt  = r_beep_cnt;

    if (w_tick) begin
      // Running beep counts down; a new beep loaded below overrides it
      if (r_beep_cnt != BEEP_W'(0)) begin
        w_beep_nxt = r_beep_cnt - BEEP_W'(1);
      end else begin
        w_beep_nxt = r_beep_cnt;
      end

      case (r_state)
        ST_LOCKED: begin
          if (w_press_enter) begin
            w_state_nxt = ST_ENTRY;
            w_code_nxt  = CODE_W'(0);
            w_idx_nxt   = IDX_W'(0);
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end

        ST_ENTRY: begin
          // One action per tick: enter beats next beats toggle
          if (w_press_enter) begin
            w_state_nxt = ST_CHECK;
          end else if (w_press_next) begin
            if (r_idx == IDX_W'(DIGITS - 1)) begin
              w_idx_nxt = IDX_W'(0);
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else if (w_press_toggle) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (r_idx == IDX_W'(i)) begin
                w_code_nxt[i*DIGIT_W +: DIGIT_W] = r_code[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
              end else begin
                w_code_nxt[i*DIGIT_W +: DIGIT_W] = r_code[i*DIGIT_W +: DIGIT_W];
              end
            end
          end else begin
            w_state_nxt = ST_ENTRY;
          end
        end

        ST_CHECK: begin
          if (r_code == PASSWORD) begin
            w_state_nxt = ST_UNLOCKED;
            w_tries_nxt = TRY_W'(MAX_TRIES);
            w_idle_nxt  = IDLE_W'(0);
            w_beep_nxt  = BEEP_W'(BEEP_SHORT);
          end else if (r_tries > TRY_W'(1)) begin
            w_state_nxt = ST_ERROR;
            w_tries_nxt = r_tries - TRY_W'(1);
            w_beep_nxt  = BEEP_W'(BEEP_LONG);
          end else begin
            w_state_nxt = ST_LOCKOUT;
            w_tries_nxt = TRY_W'(0);
            w_lock_nxt  = LOCK_W'(LOCKOUT_TICKS);
            w_beep_nxt  = BEEP_W'(BEEP_LONG);
          end
        end

        ST_ERROR: begin
          if (w_press_enter) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt = ST_ERROR;
          end
        end

        ST_UNLOCKED: begin
          if (w_press_enter) begin
            w_state_nxt = ST_LOCKED;
            w_idle_nxt  = IDLE_W'(0);
          end else if (w_press_any) begin
            w_idle_nxt = IDLE_W'(0);
          end else if (RELOCK_TICKS != 0) begin
            // Last idle tick before the count would reach RELOCK_TICKS
            if (r_idle_cnt == IDLE_W'(RELOCK_LAST)) begin
              w_state_nxt = ST_LOCKED;
              w_idle_nxt  = IDLE_W'(0);
            end else begin
              w_idle_nxt = r_idle_cnt + IDLE_W'(1);
            end
          end else begin
            w_idle_nxt = IDLE_W'(0);
          end
        end

        ST_LOCKOUT: begin
          // Buttons are ignored; leave on the tick the count reaches zero
          if (r_lock_cnt <= LOCK_W'(1)) begin
            w_state_nxt = ST_LOCKED;
            w_lock_nxt  = LOCK_W'(0);
            w_tries_nxt = TRY_W'(MAX_TRIES);
          end else begin
            w_lock_nxt = r_lock_cnt - LOCK_W'(1);
          end
        end

        default: begin
          w_state_nxt = ST_LOCKED;
        end
      endcase
    end else begin
      w_beep_nxt = r_beep_cnt;
    end
  end

  // FSM state register
  always_ff @(posedge hw_clk) begin
    if (btn_reset) begin
      r_state <= ST_LOCKED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Code, digit index and counter registers
  always_ff @(posedge hw_clk) begin
    if (btn_reset) begin
      r_code     <= CODE_W'(0);
      r_idx      <= IDX_W'(0);
      r_tries    <= TRY_W'(MAX_TRIES);
      r_lock_cnt <= LOCK_W'(0);
      r_idle_cnt <= IDLE_W'(0);
      r_beep_cnt <= BEEP_W'(0);
    end else begin
      r_code     <= w_code_nxt;
      r_idx      <= w_idx_nxt;
      r_tries    <= w_tries_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_beep_cnt <= w_beep_nxt;
    end
  end

  // Output registers follow the state and beep count being entered
  always_ff @(posedge hw_clk) begin
    if (btn_reset) begin
      r_led        <= LED_LOCKED;
      r_buzzer     <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      r_led        <= led_of(w_state_nxt);
      r_buzzer     <= (w_beep_nxt != BEEP_W'(0));
      r_locked_out <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  assign led_red    = r_led[2];
  assign led_green  = r_led[1];
  assign led_blue   = r_led[0];
  assign buzzer     = r_buzzer;
  assign locked_out = r_locked_out;
  assign digit_idx  = r_idx;
  assign tries_left = r_tries;

endmodule

// File: tb/tb_lock_fsm_multi.sv
// Self-checking bench for lock_fsm_multi: a table of press steps with expected
// outputs, run through a scoreboard queue, plus hand-written reset sequences.
module tb_lock_fsm_multi;

  localparam logic [2:0] L_LOCKED = 3'b011;
  localparam logic [2:0] L_BLUE   = 3'b110;
  localparam logic [2:0] L_GREEN  = 3'b101;
  localparam logic [2:0] L_LOCKO  = 3'b010;
  localparam logic [2:0] L_OFF    = 3'b111;
  localparam logic [2:0] B_NONE   = 3'b000;
  localparam logic [2:0] B_T      = 3'b001;
  localparam logic [2:0] B_N      = 3'b010;
  localparam logic [2:0] B_E      = 3'b100;

  logic       hw_clk     = 1'b0;
  logic       btn_reset  = 1'b1;
  logic       btn_toggle = 1'b1;
  logic       btn_next   = 1'b1;
  logic       btn_enter  = 1'b1;
  logic       led_red, led_green, led_blue, buzzer, locked_out;
  logic [1:0] digit_idx;
  logic [1:0] tries_left;

  always #5 hw_clk = ~hw_clk;

  lock_fsm_multi #(
    .DIGITS        (4),
    .DIGIT_W       (2),
    .PASSWORD      (8'h9C),
    .TICK_DIV      (4),
    .MAX_TRIES     (2),
    .LOCKOUT_TICKS (5),
    .RELOCK_TICKS  (8),
    .BEEP_SHORT    (10),
    .BEEP_LONG     (25)
  ) dut (
    .hw_clk     (hw_clk),
    .btn_reset  (btn_reset),
    .btn_toggle (btn_toggle),
    .btn_next   (btn_next),
    .btn_enter  (btn_enter),
    .led_red    (led_red),
    .led_green  (led_green),
    .led_blue   (led_blue),
    .buzzer     (buzzer),
    .digit_idx  (digit_idx),
    .tries_left (tries_left),
    .locked_out (locked_out)
  );

  // One step: press btn during one tick, then stay released for extra ticks
  typedef struct {
    string      tag;
    logic [2:0] btn;
    int         extra;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [8:0] pk(input logic [2:0] led, input logic [1:0] idx,
                                    input logic [1:0] tr, input logic lo, input logic bz);
    return {led, idx, tr, lo, bz};
  endfunction

  function automatic void add(input string tag, input logic [2:0] btn, input int extra,
                              input logic [2:0] led, input logic [1:0] idx,
                              input logic [1:0] tr, input logic lo, input logic bz);
    vec_t v;
    v.tag   = tag;
    v.btn   = btn;
    v.extra = extra;
    v.exp   = pk(led, idx, tr, lo, bz);
    vecs.push_back(v);
  endfunction

  // Pop the oldest expectation and compare it with the DUT outputs
  task automatic check_now();
    sb_t        e;
    logic [8:0] got;
    got = {led_red, led_green, led_blue, digit_idx, tries_left, locked_out, buzzer};
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard: got empty queue, want an expectation");
    end else begin
      e = sb_q.pop_front();
      if (got === e.exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got led=%b idx=%0d tries=%0d lo=%b bz=%b, want led=%b idx=%0d tries=%0d lo=%b bz=%b",
                 e.tag, got[8:6], got[5:4], got[3:2], got[1], got[0],
                 e.exp[8:6], e.exp[5:4], e.exp[3:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  // Starts just after the negedge following a tick boundary; ends the same way
  task automatic apply(input vec_t v);
    sb_t s;
    s.tag = v.tag;
    s.exp = v.exp;
    sb_q.push_back(s);
    btn_toggle = ~v.btn[0];
    btn_next   = ~v.btn[1];
    btn_enter  = ~v.btn[2];
    repeat (2) @(posedge hw_clk);
    @(negedge hw_clk);
    btn_toggle = 1'b1;
    btn_next   = 1'b1;
    btn_enter  = 1'b1;
    repeat (2) @(posedge hw_clk);
    repeat (v.extra * 4) @(posedge hw_clk);
    @(negedge hw_clk);
    check_now();
  endtask

  // Reset in the middle of a tick period; the reset edge becomes the new boundary
  task automatic mid_reset(input string tag);
    sb_t s;
    repeat (2) @(posedge hw_clk);
    @(negedge hw_clk);
    btn_reset = 1'b1;
    s.tag = tag;
    s.exp = pk(L_LOCKED, 2'd0, 2'd2, 1'b0, 1'b0);
    sb_q.push_back(s);
    @(posedge hw_clk);
    @(negedge hw_clk);
    check_now();
    btn_reset = 1'b0;
  endtask

  initial begin
    // Correct code 0,3,1,2; beep 10 ticks outlives the 8-tick relock
    add("open",       B_E, 1, L_BLUE,   2'd0, 2'd2, 1'b0, 1'b0);
    add("next_d1",    B_N, 1, L_BLUE,   2'd1, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add("tog_d1", B_T, 1, L_BLUE, 2'd1, 2'd2, 1'b0, 1'b0);
    add("next_d2",    B_N, 1, L_BLUE,   2'd2, 2'd2, 1'b0, 1'b0);
    add("tog_d2",     B_T, 1, L_BLUE,   2'd2, 2'd2, 1'b0, 1'b0);
    add("next_d3",    B_N, 1, L_BLUE,   2'd3, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) add("tog_d3", B_T, 1, L_BLUE, 2'd3, 2'd2, 1'b0, 1'b0);
    add("check_ok",   B_E, 0, L_OFF,    2'd3, 2'd2, 1'b0, 1'b0);
    add("unlocked",   B_NONE, 0, L_GREEN, 2'd3, 2'd2, 1'b0, 1'b1);
    add("idle7",      B_NONE, 6, L_GREEN, 2'd3, 2'd2, 1'b0, 1'b1);
    add("relock8",    B_NONE, 0, L_LOCKED, 2'd3, 2'd2, 1'b0, 1'b1);
    add("beep_t9",    B_NONE, 0, L_LOCKED, 2'd3, 2'd2, 1'b0, 1'b1);
    add("beep_end10", B_NONE, 0, L_LOCKED, 2'd3, 2'd2, 1'b0, 1'b0);
    // Two wrong codes: ERROR then LOCKOUT for 5 ticks
    add("wr1_open",   B_E, 1, L_BLUE,   2'd0, 2'd2, 1'b0, 1'b0);
    add("wr1_check",  B_E, 0, L_OFF,    2'd0, 2'd2, 1'b0, 1'b0);
    add("error",      B_NONE, 0, L_BLUE, 2'd0, 2'd1, 1'b0, 1'b1);
    add("err_to_lck", B_E, 1, L_LOCKED, 2'd0, 2'd1, 1'b0, 1'b1);
    add("wr2_open",   B_E, 1, L_BLUE,   2'd0, 2'd1, 1'b0, 1'b1);
    add("wr2_check",  B_E, 0, L_OFF,    2'd0, 2'd1, 1'b0, 1'b1);
    add("lockout",    B_NONE, 0, L_LOCKO, 2'd0, 2'd0, 1'b1, 1'b1);
    add("lo_ignore",  3'b111, 1, L_LOCKO, 2'd0, 2'd0, 1'b1, 1'b1);
    add("lo_t4",      B_NONE, 1, L_LOCKO, 2'd0, 2'd0, 1'b1, 1'b1);
    add("lo_exit5",   B_NONE, 0, L_LOCKED, 2'd0, 2'd2, 1'b0, 1'b1);
    add("long_t24",   B_NONE, 18, L_LOCKED, 2'd0, 2'd2, 1'b0, 1'b1);
    add("long_end25", B_NONE, 0, L_LOCKED, 2'd0, 2'd2, 1'b0, 1'b0);
    // Wrap-around: digit0 x4 -> 0, next x5 -> idx 1, digit2 x5 -> 1, simultaneous next+toggle
    add("wp_open",    B_E, 1, L_BLUE,   2'd0, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) add("wp_tog_d0", B_T, 1, L_BLUE, 2'd0, 2'd2, 1'b0, 1'b0);
    add("wp_next1",   B_N, 1, L_BLUE,   2'd1, 2'd2, 1'b0, 1'b0);
    add("wp_next2",   B_N, 1, L_BLUE,   2'd2, 2'd2, 1'b0, 1'b0);
    add("wp_next3",   B_N, 1, L_BLUE,   2'd3, 2'd2, 1'b0, 1'b0);
    add("wp_next_wrap", B_N, 1, L_BLUE, 2'd0, 2'd2, 1'b0, 1'b0);
    add("wp_next5",   B_N, 1, L_BLUE,   2'd1, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add("wp_tog_d1", B_T, 1, L_BLUE, 2'd1, 2'd2, 1'b0, 1'b0);
    add("wp_next_d2", B_N, 1, L_BLUE,   2'd2, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) add("wp_tog_d2", B_T, 1, L_BLUE, 2'd2, 2'd2, 1'b0, 1'b0);
    add("wp_next_d3", B_N, 1, L_BLUE,   2'd3, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) add("wp_tog_d3", B_T, 1, L_BLUE, 2'd3, 2'd2, 1'b0, 1'b0);
    add("simul_nt",   3'b011, 1, L_BLUE, 2'd0, 2'd2, 1'b0, 1'b0);
    add("wp_check",   B_E, 0, L_OFF,    2'd0, 2'd2, 1'b0, 1'b0);
    add("wp_unlock",  B_NONE, 0, L_GREEN, 2'd0, 2'd2, 1'b0, 1'b1);
    // Auto-relock restarted by a press at idle tick 6
    add("rl_idle5",   B_NONE, 4, L_GREEN, 2'd0, 2'd2, 1'b0, 1'b1);
    add("rl_press6",  B_T, 0, L_GREEN,  2'd0, 2'd2, 1'b0, 1'b1);
    add("rl_held13",  B_NONE, 6, L_GREEN, 2'd0, 2'd2, 1'b0, 1'b0);
    add("rl_relock14", B_NONE, 0, L_LOCKED, 2'd0, 2'd2, 1'b0, 1'b0);
    // digit0 toggled x5 gives 1, so the code mismatches
    add("x5_open",    B_E, 1, L_BLUE,   2'd0, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) add("x5_tog_d0", B_T, 1, L_BLUE, 2'd0, 2'd2, 1'b0, 1'b0);
    add("x5_next_d1", B_N, 1, L_BLUE,   2'd1, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add("x5_tog_d1", B_T, 1, L_BLUE, 2'd1, 2'd2, 1'b0, 1'b0);
    add("x5_next_d2", B_N, 1, L_BLUE,   2'd2, 2'd2, 1'b0, 1'b0);
    add("x5_tog_d2",  B_T, 1, L_BLUE,   2'd2, 2'd2, 1'b0, 1'b0);
    add("x5_next_d3", B_N, 1, L_BLUE,   2'd3, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) add("x5_tog_d3", B_T, 1, L_BLUE, 2'd3, 2'd2, 1'b0, 1'b0);
    add("x5_check",   B_E, 0, L_OFF,    2'd3, 2'd2, 1'b0, 1'b0);
    add("x5_error",   B_NONE, 0, L_BLUE, 2'd3, 2'd1, 1'b0, 1'b1);
    add("x5_to_lck",  B_E, 1, L_LOCKED, 2'd3, 2'd1, 1'b0, 1'b1);
    add("mid_open",   B_E, 1, L_BLUE,   2'd0, 2'd1, 1'b0, 1'b1);
    add("mid_next",   B_N, 1, L_BLUE,   2'd1, 2'd1, 1'b0, 1'b1);

    // Reset state
    @(posedge hw_clk);
    @(negedge hw_clk);
    begin
      sb_t s;
      s.tag = "reset_state";
      s.exp = pk(L_LOCKED, 2'd0, 2'd2, 1'b0, 1'b0);
      sb_q.push_back(s);
    end
    check_now();
    btn_reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-entry, mid-beep and with one try used
    mid_reset("reset_mid");
    begin
      vec_t v;
      v.tag = "post_rst_idle"; v.btn = B_NONE; v.extra = 1;
      v.exp = pk(L_LOCKED, 2'd0, 2'd2, 1'b0, 1'b0);
      apply(v);
      v.tag = "post_rst_open"; v.btn = B_E; v.extra = 1;
      v.exp = pk(L_BLUE, 2'd0, 2'd2, 1'b0, 1'b0);
      apply(v);
      v.tag = "post_rst_check"; v.btn = B_E; v.extra = 0;
      v.exp = pk(L_OFF, 2'd0, 2'd2, 1'b0, 1'b0);
      apply(v);
      v.tag = "post_rst_err"; v.btn = B_NONE; v.extra = 0;
      v.exp = pk(L_BLUE, 2'd0, 2'd1, 1'b0, 1'b1);
      apply(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
